// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI master controller.
// Holds the FSM state enum, pad idle levels and the length-width helper.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    HOLD,
    DONE
  } spi_state_e;

  localparam logic SCK_IDLE    = 1'b0;
  localparam logic SS_INACTIVE = 1'b1;
  localparam logic MOSI_IDLE   = 1'b1;

  function automatic int len_w(input int dw);
    return $clog2(dw) + 1;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SPI phase timer: load sets the phase length, then counts down.
// Ports: clock, reset, load, div_val in; phase_end out (count == 1).
module spi_clk_div #(
  parameter int DIV_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [DIV_W-1:0] div_val,
  output logic             phase_end
);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= div_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign phase_end = (cnt == DIV_W'(1));

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: one request in, sck/ss_n/mosi out, one response pulse.
// Ports: clock, reset, cfg_div, req_*, resp_*, sck, ss_n, mosi, miso.
// Option SPI_MASTER_LSB_FIRST_EN: LSB-first shifting, same timing.
module spi_master_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int NUM_SS = 8,
  parameter  int DIV_W  = 8,
  localparam int LEN_W  = len_w(DATA_W),
  localparam int SEL_W  = $clog2(NUM_SS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_tx_data,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [SEL_W-1:0]  req_sel,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rx_data,
  output logic              sck,
  output logic [NUM_SS-1:0] ss_n,
  output logic              mosi,
  input  logic              miso
);

  spi_state_e state_q, nxt;

  logic [DATA_W-1:0] tx_q, rx_q, rx_res, mask;
  logic [LEN_W-1:0]  len_q, bit_cnt, eff_len;
  logic [SEL_W-1:0]  sel_q;
  logic [DIV_W-1:0]  div_q, eff_div, div_val;
  logic              mosi_q, accept, load;
  logic              phase_end, fall, last_bit, active;

  assign accept  = req_valid && req_ready;
  assign eff_div = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
  assign eff_len = (req_len == '0 || req_len > LEN_W'(DATA_W))
                 ? LEN_W'(DATA_W) : req_len;
  assign div_val = accept ? eff_div : div_q;
  assign fall    = (state_q == SHIFT_HI) && phase_end;
  assign last_bit = (bit_cnt + 1'b1) == len_q;

  spi_clk_div #(.DIV_W(DIV_W)) u_div (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .div_val   (div_val),
    .phase_end (phase_end)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= nxt;
  end

  always_comb begin
    nxt  = state_q;
    load = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        nxt  = SETUP;
        load = 1'b1;
      end
      SETUP: if (phase_end) begin
        nxt  = SHIFT_HI;
        load = 1'b1;
      end
      SHIFT_HI: if (phase_end) begin
        nxt  = SHIFT_LO;
        load = 1'b1;
      end
      SHIFT_LO: if (phase_end) begin
        nxt  = (bit_cnt == len_q) ? HOLD : SHIFT_HI;
        load = 1'b1;
      end
      HOLD: if (phase_end) nxt = DONE;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < DATA_W; i++) begin
      mask[i] = LEN_W'(i) < len_q;
    end
  end

`ifdef SPI_MASTER_LSB_FIRST_EN
  // First received bit sits at DATA_W-len; shift it down to bit 0.
  assign rx_res = rx_q >> (LEN_W'(DATA_W) - len_q);
`else
  assign rx_res = rx_q & mask;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_q         <= '0;
      rx_q         <= '0;
      resp_rx_data <= '0;
      len_q        <= '0;
      bit_cnt      <= '0;
      sel_q        <= '0;
      div_q        <= '0;
      mosi_q       <= MOSI_IDLE;
    end else begin
      if (accept) begin
        tx_q    <= req_tx_data;
        rx_q    <= '0;
        len_q   <= eff_len;
        bit_cnt <= '0;
        sel_q   <= req_sel;
        div_q   <= eff_div;
`ifdef SPI_MASTER_LSB_FIRST_EN
        mosi_q  <= req_tx_data[0];
`else
        mosi_q  <= req_tx_data[DATA_W-1];
`endif
      end else if (fall) begin
        bit_cnt <= bit_cnt + 1'b1;
`ifdef SPI_MASTER_LSB_FIRST_EN
        rx_q    <= {miso, rx_q[DATA_W-1:1]};
        tx_q    <= tx_q >> 1;
        mosi_q  <= last_bit ? MOSI_IDLE : tx_q[1];
`else
        rx_q    <= {rx_q[DATA_W-2:0], miso};
        tx_q    <= tx_q << 1;
        mosi_q  <= last_bit ? MOSI_IDLE : tx_q[DATA_W-2];
`endif
      end
      if (state_q == HOLD && phase_end) begin
        resp_rx_data <= rx_res;
      end
    end
  end

  // Outputs decode straight from state so an async reset
  // drops sck and releases the selects in the same cycle.
  assign active = (state_q == SETUP) || (state_q == SHIFT_HI)
               || (state_q == SHIFT_LO) || (state_q == HOLD);

  always_comb begin
    ss_n = {NUM_SS{SS_INACTIVE}};
    for (int i = 0; i < NUM_SS; i++) begin
      if (active && sel_q == SEL_W'(i)) ss_n[i] = ~SS_INACTIVE;
    end
  end

  assign sck        = (state_q == SHIFT_HI) ? ~SCK_IDLE : SCK_IDLE;
  assign mosi       = mosi_q;
  assign resp_valid = (state_q == DONE);
  assign req_ready  = (state_q == IDLE) && !reset;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: loopback, echo slave, edge cases,
// busy handling and mid-transfer reset.
module tb_spi_master_ctrl;

  localparam int DW = 16;
  localparam int NS = 6;

`ifdef SPI_MASTER_LSB_FIRST_EN
  localparam logic [15:0] TX1 = 16'h003C, RX1 = 16'h003C;
  localparam logic [15:0] TX2 = 16'h00A5, RX2 = 16'hA500;
  localparam logic [15:0] TX4 = 16'h000F;
  localparam logic [15:0] TX5 = 16'h001A, RX5 = 16'h001A;
  localparam logic [15:0] TX6 = 16'h0003;
`else
  localparam logic [15:0] TX1 = 16'h3C00, RX1 = 16'h003C;
  localparam logic [15:0] TX2 = 16'hA500, RX2 = 16'h00A5;
  localparam logic [15:0] TX4 = 16'hF000;
  localparam logic [15:0] TX5 = 16'h5800, RX5 = 16'h000B;
  localparam logic [15:0] TX6 = 16'hC000;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    cfg_div = 8'd1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [DW-1:0] req_tx_data = '0;
  logic [4:0]    req_len = '0;
  logic [2:0]    req_sel = '0;
  logic          resp_valid;
  logic [DW-1:0] resp_rx_data;
  logic          sck;
  logic [NS-1:0] ss_n;
  logic          mosi;
  logic          miso;

  spi_master_ctrl #(.DATA_W(DW), .NUM_SS(NS), .DIV_W(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .cfg_div      (cfg_div),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_tx_data  (req_tx_data),
    .req_len      (req_len),
    .req_sel      (req_sel),
    .resp_valid   (resp_valid),
    .resp_rx_data (resp_rx_data),
    .sck          (sck),
    .ss_n         (ss_n),
    .mosi         (mosi),
    .miso         (miso)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] rx;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n0, n1, t;
  int miso_mode = 0;
  int sck_rises = 0;
  int first_low, last_low;
  logic [NS-1:0] seen_low = '0;
  int echo_cnt = 0;
  logic [7:0] echo_in = '0, echo_out = '0;
  logic echo_miso = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  always_comb begin
    case (miso_mode)
      0:       miso = mosi;
      1:       miso = echo_miso;
      default: miso = 1'b1;
    endcase
  end

  // Echo slave on select 3: takes 8 bits, then returns that byte MSB-first.
  always @(posedge sck) begin
    sck_rises++;
    if (ss_n[3] == 1'b0) begin
      echo_cnt++;
      if (echo_cnt <= 8) begin
        echo_in   = {echo_in[6:0], mosi};
        echo_miso = 1'b0;
        if (echo_cnt == 8) echo_out = echo_in;
      end else begin
        echo_miso = echo_out[7];
        echo_out  = echo_out << 1;
      end
    end
  end

  always @(posedge ss_n[3]) begin
    echo_cnt  = 0;
    echo_miso = 1'b0;
  end

  always @(negedge clock) begin
    seen_low = seen_low | ~ss_n;
    if (~ss_n != '0) begin
      if (first_low < 0) first_low = cyc;
      last_low = cyc;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin : mon
    exp_t e;
    if (resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp rx=%h cyc=%0d", resp_rx_data, cyc);
      end else begin
        e = sb.pop_front();
        chk("resp_rx", 32'(resp_rx_data), 32'(e.rx));
        chk("resp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic issue(input logic [7:0] d, input logic [4:0] l,
                       input logic [15:0] tx, input logic [2:0] s,
                       input int m);
    int w;
    w = 0;
    @(negedge clock);
    while (req_ready !== 1'b1 && w < 200) begin
      @(negedge clock);
      w++;
    end
    if (w >= 200) chk("ready_timeout", 0, 1);
    cfg_div     = d;
    req_len     = l;
    req_tx_data = tx;
    req_sel     = s;
    miso_mode   = m;
    sck_rises   = 0;
    seen_low    = '0;
    first_low   = -1;
    last_low    = -1;
    n0          = cyc;
    req_valid   = 1'b1;
    @(negedge clock);
    req_valid   = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 1000) begin
      @(negedge clock);
      w++;
    end
    if (w >= 1000) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic run(input logic [7:0] d, input logic [4:0] l,
                     input logic [15:0] tx, input logic [2:0] s,
                     input int m, input logic [15:0] rx, input int lat);
    issue(d, l, tx, s, m);
    sb.push_back('{rx: rx, cyc: n0 + lat});
    drain();
  endtask

  initial begin
    first_low = -1;
    last_low  = -1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_sck", 32'(sck), 0);
    chk("rst_ss_n", 32'(ss_n), 32'h3F);
    chk("rst_mosi", 32'(mosi), 1);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_rx", 32'(resp_rx_data), 0);

    // Loopback, div 1, len 8.
    issue(8'd1, 5'd8, TX1, 3'd0, 0);
    sb.push_back('{rx: RX1, cyc: n0 + 19});
    chk("t1_first_mosi", 32'(mosi), 0);
    chk("t1_setup_ss", 32'(ss_n), 32'h3E);
    drain();
    chk("t1_rises", sck_rises, 8);
    chk("t1_sel_mask", 32'(seen_low), 32'h01);
    chk("t1_ss_first", first_low, n0 + 1);
    chk("t1_ss_last", last_low, n0 + 18);
    repeat (3) @(negedge clock);
    chk("t1_rx_held", 32'(resp_rx_data), 32'(RX1));

    // Echo slave on select 3, div 2, len 16.
    run(8'd2, 5'd16, TX2, 3'd3, 1, RX2, 69);
    chk("t2_rises", sck_rises, 16);
    chk("t2_sel_mask", 32'(seen_low), 32'h08);

    // len 0 and div 0 -> 16 bits at div 1, miso held high.
    run(8'd0, 5'd0, 16'h1234, 3'd1, 2, 16'hFFFF, 35);
    chk("t3_rises", sck_rises, 16);
    chk("t3_sel_mask", 32'(seen_low), 32'h02);

    // len above DATA_W clamps to 16.
    run(8'd1, 5'd20, 16'h0F0F, 3'd0, 2, 16'hFFFF, 35);
    chk("t3b_rises", sck_rises, 16);

    // Out-of-range select: transfer runs, no select asserted.
    run(8'd1, 5'd4, TX4, 3'd6, 0, 16'h000F, 11);
    chk("t4_sel_mask", 32'(seen_low), 32'h00);
    chk("t4_rises", sck_rises, 4);

    // Busy: req_valid held, cfg_div changed mid-transfer.
    @(negedge clock);
    cfg_div     = 8'd3;
    req_len     = 5'd5;
    req_tx_data = TX5;
    req_sel     = 3'd1;
    miso_mode   = 0;
    n0          = cyc;
    req_valid   = 1'b1;
    sb.push_back('{rx: RX5, cyc: n0 + 37});
    @(negedge clock);
    cfg_div     = 8'd1;
    req_len     = 5'd2;
    req_tx_data = TX6;
    chk("busy_ready", 32'(req_ready), 0);
    t = 0;
    while (req_ready !== 1'b1 && t < 200) begin
      @(negedge clock);
      t++;
    end
    chk("second_accept_cycle", cyc, n0 + 38);
    n1 = cyc;
    sb.push_back('{rx: 16'h0003, cyc: n1 + 7});
    @(negedge clock);
    req_valid = 1'b0;
    drain();

    // Reset during SHIFT_HI of bit 3.
    issue(8'd1, 5'd8, 16'hFF00, 3'd2, 0);
    t = 0;
    while (cyc < n0 + 6 && t < 50) begin
      @(negedge clock);
      t++;
    end
    chk("pre_rst_sck", 32'(sck), 1);
    chk("pre_rst_ss", 32'(ss_n[2]), 0);
    reset = 1'b1;
    #1;
    chk("mid_rst_sck", 32'(sck), 0);
    chk("mid_rst_ss_n", 32'(ss_n), 32'h3F);
    chk("mid_rst_mosi", 32'(mosi), 1);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (30) @(negedge clock);
    chk("post_rst_ready", 32'(req_ready), 1);

    run(8'd1, 5'd8, TX1, 3'd0, 0, RX1, 19);
    chk("t6_rises", sck_rises, 8);

`ifdef SPI_MASTER_LSB_FIRST_EN
    issue(8'd1, 5'd8, 16'h0001, 3'd0, 0);
    sb.push_back('{rx: 16'h0001, cyc: n0 + 19});
    chk("lsb_first_mosi", 32'(mosi), 1);
    drain();
`endif

    repeat (5) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- SPI master controller (mode 0, sck idle low) that sequences transfers to SPI slave peripherals on the perip bus, e.g. the bit-reverse slave.
- Takes one request at a time: tx data, bit length and slave index.
- Owns sck, ss_n and mosi; captures miso; returns the received bits on a one-cycle response pulse.
- Sits between the CPU-side bus bridge and the SPI pads.

Parameters:
- DATA_W, 16, maximum bits per transfer (transfers are MSB-first by default).
- NUM_SS, 8, number of slave-select lines.
- DIV_W, 8, width of the sck half-period divider input.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cfg_div  in  DIV_W  sck half-period in clock cycles; 0 is treated as 1; sampled at request accept.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_tx_data  in  DATA_W  bits to send, left-aligned (bit DATA_W-1 goes first).
- req_len  in  $clog2(DATA_W)+1  bit count; 0 is treated as DATA_W; values above DATA_W are clamped to DATA_W.
- req_sel  in  $clog2(NUM_SS)  slave index; values >= NUM_SS select no slave, but the transfer still runs.
- resp_valid  out  1  one-cycle pulse at transfer end.
- resp_rx_data  out  DATA_W  received bits, right-aligned in the low len bits, upper bits zero; held until the next response.
- sck  out  1  SPI clock.
- ss_n  out  NUM_SS  active-low selects.
- mosi  out  1  master out.
- miso  in  1  master in.

Behaviour:
- Reset (async): state IDLE; sck=0; ss_n all 1; mosi=1; resp_valid=0; resp_rx_data=0; req_ready=1 after reset deasserts. Mid-transfer reset deasserts ss_n immediately and aborts with no response.
- Accept: in IDLE, req_valid&&req_ready latches tx, len, sel and div (eff_div = max(cfg_div,1)). Call this cycle 0.
- SETUP: cycles 1..eff_div. ss_n[sel]=0, sck=0, mosi=tx[DATA_W-1].
- SHIFT, per bit:
  - HIGH phase: eff_div cycles with sck=1.
  - LOW phase: eff_div cycles with sck=0.
  - On the first cycle of LOW (the falling-edge transition), miso is sampled into rx_shift as {rx_shift, miso}. In the same cycle mosi advances to the next tx bit, or goes to 1 after the last bit.
  - Bit counter increments at each falling edge. After len falling edges, go to HOLD.
- HOLD: sck=0, ss_n still asserted. Lasts eff_div cycles, overlapping the last bit's LOW phase as a separate count.
- DONE: one cycle. ss_n all 1, resp_valid=1, resp_rx_data = rx_shift masked to len bits. Next cycle is IDLE.
- Latency: resp_valid asserts at cycle 1 + eff_div*(2*len+2) after accept.
- Slaves sample mosi on sck rising and update miso on rising; the master samples one half-period later.
- req_valid while busy: ignored (req_ready=0). No queueing.
- A new request may be accepted the cycle after DONE.
- Divider counter is DIV_W bits. It reloads at every phase change and never wraps mid-phase.
- cfg_div changes during a transfer have no effect.
- State encoding: IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, DONE. Any illegal state goes to IDLE with ss_n deasserted.

Optional Feature:
- SPI_MASTER_LSB_FIRST_EN
  - Defined: tx is right-aligned, bit 0 is sent first; received bits fill from bit len-1 downward (rx[i] = i-th bit received); upper bits zero.
  - Undefined: MSB-first as above.
- Cycle timing is identical in both cases.

Decomposition:
- Package spi_ctrl_pkg:
  - state enum spi_state_e;
  - localparams SCK_IDLE=0, SS_INACTIVE=1, MOSI_IDLE=1;
  - len width function.
- One sub-module, spi_clk_div:
  - loads eff_div on load; counts down;
  - emits a phase_end pulse when the count reaches 1;
  - the FSM uses phase_end to advance.

Test Plan:
- Loopback (miso tied to mosi), div=1, len=8, tx=0x3C00 -> rx=0x003C. resp_valid at cycle 19. Exactly 8 sck rising edges; ss_n[sel] low from cycle 1 through 18.
- Echo slave model (bit-reverse style: 8 bits in, then echoes the byte), div=2, len=16, tx=0xA500, sel=3 -> rx=0x00A5 (the echoed 0xA5 in the last 8 bits). Only ss_n[3] toggles. resp at cycle 1+2*34=69.
- Edge values: len=0, div=0 -> 16-bit transfer at div 1; req_sel=NUM_SS -> all ss_n stay high; miso=1 -> rx=0xFFFF.
- Busy handling: req_valid held during a transfer -> req_ready=0. A second request is accepted exactly one cycle after the resp_valid pulse. Changing cfg_div mid-transfer does not change the sck period.
- Reset mid-transfer: assert reset in SHIFT_HI of bit 3 -> same cycle sck=0, ss_n all 1; no resp_valid. The next transfer completes normally.
- With SPI_MASTER_LSB_FIRST_EN, loopback, len=8, tx=0x0001 -> first mosi bit 1, rx=0x0001.
